// File: rtl/fir_pkg.sv
// Shared definitions for the 5x5 systolic FIR datapath and its line-buffer front end.
package fir_pkg;

    localparam int PIX_W    = 8;
    localparam int KERNEL_N = 5;
    localparam int LB_LINES = KERNEL_N - 1;

    typedef enum logic {
        LB_FILL = 1'b0,
        LB_RUN  = 1'b1
    } lb_state_e;

endpackage

// File: rtl/fir_line_buffer_if.sv
// Pixel-stream bundle between the raster source, the line buffer and the FIR column inputs.
interface fir_line_buffer_if;

    logic                       in_valid;
    logic                       in_sof;
    logic [fir_pkg::PIX_W-1:0]  in_pixel;
    logic [fir_pkg::PIX_W-1:0]  pixel0;
    logic [fir_pkg::PIX_W-1:0]  pixel1;
    logic [fir_pkg::PIX_W-1:0]  pixel2;
    logic [fir_pkg::PIX_W-1:0]  pixel3;
    logic [fir_pkg::PIX_W-1:0]  pixel4;
    logic                       out_valid;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  pixel0, pixel1, pixel2, pixel3, pixel4, out_valid
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output pixel0, pixel1, pixel2, pixel3, pixel4, out_valid
    );

endinterface

// File: rtl/fir_line_ram.sv
// One image line of storage: single-port, read-first, synchronous-read RAM.
// The read register only advances on enabled cycles so the output holds across input gaps.
module fir_line_ram
    import fir_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  din,
    output logic [PIX_W-1:0]  dout
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[addr];
            if (we) begin
                mem[addr] <= din;
            end
        end
    end

endmodule

// File: rtl/fir_line_buffer.sv
// Line buffer feeding 5-row pixel columns to the systolic FIR, one cycle after each accepted pixel.
// Optional top zero-padding (output height = input height) is enabled by defining FIR_LB_TOP_PAD_EN.
module fir_line_buffer
    import fir_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    fir_line_buffer_if.slave lb
);

`ifdef FIR_LB_TOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic [COL_W-1:0]    col_q, col_d, col_eff;
    logic [2:0]          rows_done_q, rows_done_d, rows_eff;
    lb_state_e           state_q, state_d, state_eff;
    logic [1:0]          wr_sel_q, wr_sel_d;
    logic [1:0]          rd_sel_q, rd_sel_d;
    logic [PIX_W-1:0]    pix4_q, pix4_d;
    logic [LB_LINES-1:0] zero_q, zero_d;
    logic                out_valid_q, out_valid_d;
    logic                ram_en;
    logic                sof;
    logic [PIX_W-1:0]    ram_dout [LB_LINES];
    logic [PIX_W-1:0]    line_out [LB_LINES];

    assign ram_en = lb.in_valid && !rst;
    assign sof    = lb.in_valid && lb.in_sof;

    // Rows shift by rotating which physical RAM is the oldest line instead of copying data:
    // the RAM selected by wr_sel holds row y-4 and is overwritten with the current row.
    for (genvar p = 0; p < LB_LINES; p++) begin : g_line
        fir_line_ram #(
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (COL_W)
        ) u_ram (
            .clk  (clk),
            .en   (ram_en),
            .we   (ram_en && (wr_sel_q == 2'(p))),
            .addr (col_eff),
            .din  (lb.in_pixel),
            .dout (ram_dout[p])
        );
    end

    always_comb begin
        col_eff     = sof ? '0 : col_q;
        rows_eff    = sof ? 3'd0 : rows_done_q;
        state_eff   = sof ? LB_FILL : state_q;
        col_d       = col_q;
        rows_done_d = rows_done_q;
        state_d     = state_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        pix4_d      = pix4_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (lb.in_valid) begin
            pix4_d      = lb.in_pixel;
            rd_sel_d    = wr_sel_q;
            out_valid_d = (state_eff == LB_RUN) || PAD_EN;
            for (int k = 0; k < LB_LINES; k++) begin
                zero_d[k] = PAD_EN && ((rows_eff + 3'(k)) < 3'(LB_LINES));
            end
            col_d       = col_eff;
            rows_done_d = rows_eff;
            state_d     = state_eff;
            if (col_eff == COL_W'(IMG_WIDTH - 1)) begin
                col_d    = '0;
                wr_sel_d = wr_sel_q + 2'd1;
                if (rows_eff < 3'(LB_LINES)) begin
                    rows_done_d = rows_eff + 3'd1;
                end
                if (rows_eff >= 3'(LB_LINES - 1)) begin
                    state_d = LB_RUN;
                end
            end else begin
                col_d = col_eff + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            rows_done_q <= 3'd0;
            state_q     <= LB_FILL;
            wr_sel_q    <= 2'd0;
            rd_sel_q    <= 2'd0;
            pix4_q      <= '0;
            zero_q      <= '1;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            rows_done_q <= rows_done_d;
            state_q     <= state_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            pix4_q      <= pix4_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    // zero_q masks lines that are padding, or RAM data not yet read since reset.
    always_comb begin
        for (int k = 0; k < LB_LINES; k++) begin
            line_out[k] = zero_q[k] ? '0 : ram_dout[rd_sel_q + 2'(k)];
        end
    end

    assign lb.pixel0    = line_out[0];
    assign lb.pixel1    = line_out[1];
    assign lb.pixel2    = line_out[2];
    assign lb.pixel3    = line_out[3];
    assign lb.pixel4    = pix4_q;
    assign lb.out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_line_buffer.sv
// Randomized scoreboard bench for fir_line_buffer with an 8-pixel-wide image.
module tb_fir_line_buffer;

    localparam int W = 8;

`ifdef FIR_LB_TOP_PAD_EN
    localparam bit PAD_MODEL = 1'b1;
`else
    localparam bit PAD_MODEL = 1'b0;
`endif

    typedef struct {
        logic [7:0] p [5];
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    fir_line_buffer_if bus ();

    fir_line_buffer #(
        .IMG_WIDTH (W),
        .COL_W     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lb  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the current frame as a map from (row, col) to pixel value.
    logic [7:0] frame_px [int];
    int         m_row = 0;
    int         m_col = 0;
    logic       last_valid = 1'b0;
    logic       known = 1'b1;
    exp_t       last_exp;
    exp_t       sb [$];

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        frame_px.delete();
        m_row = 0;
        m_col = 0;
        known = 1'b1;
        for (int k = 0; k < 5; k++) last_exp.p[k] = 8'h00;
    endtask

    task automatic modelPixel(input logic sof, input logic [7:0] pix);
        exp_t e;
        int   r;
        if (sof) begin
            frame_px.delete();
            m_row = 0;
            m_col = 0;
        end
        for (int k = 0; k < 4; k++) begin
            r = m_row - 4 + k;
            e.p[k] = (r >= 0) ? frame_px[r * W + m_col] : 8'h00;
        end
        e.p[4] = pix;
        last_valid = PAD_MODEL || (m_row >= 4);
        frame_px[m_row * W + m_col] = pix;
        if (last_valid) begin
            sb.push_back(e);
            last_exp = e;
            known = 1'b1;
        end else begin
            known = 1'b0;
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row++;
        end
    endtask

    function automatic logic [7:0] outPix(input int k);
        case (k)
            0:       return bus.pixel0;
            1:       return bus.pixel1;
            2:       return bus.pixel2;
            3:       return bus.pixel3;
            default: return bus.pixel4;
        endcase
    endfunction

    task automatic applyStimulus(input logic v, input logic sof, input logic [7:0] pix);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_pixel = pix;
        if (v) modelPixel(sof, pix);
        @(posedge clk);
        #1;
        if (v) begin
            checkOutput("out_valid", int'(bus.out_valid), int'(last_valid));
        end else begin
            checkOutput("gap_out_valid", int'(bus.out_valid), 0);
            if (known) begin
                for (int k = 0; k < 5; k++) begin
                    checkOutput($sformatf("gap_hold_pixel%0d", k), int'(outPix(k)), int'(last_exp.p[k]));
                end
            end
        end
    endtask

    task automatic doReset();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("reset_pixel%0d", k), int'(outPix(k)), 0);
        end
    endtask

    task automatic checkColumn(input string name, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        checkOutput({name, "_pixel0"}, int'(bus.pixel0), int'(e0));
        checkOutput({name, "_pixel1"}, int'(bus.pixel1), int'(e1));
        checkOutput({name, "_pixel2"}, int'(bus.pixel2), int'(e2));
        checkOutput({name, "_pixel3"}, int'(bus.pixel3), int'(e3));
        checkOutput({name, "_pixel4"}, int'(bus.pixel4), int'(e4));
    endtask

    // Monitor: every presented column must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL sb_unexpected_valid: got out_valid=1, expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int k = 0; k < 5; k++) begin
                    checkOutput($sformatf("sb_pixel%0d", k), int'(outPix(k)), int'(e.p[k]));
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        $display("[TB] raster stream, continuous valid");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus(1'b1, 1'b0, 8'(16 * r + c));
                if (r == 4 && c == 0) checkOutput("wrap_run_out_valid", int'(bus.out_valid), 1);
                if (r == 4 && c == 2) checkColumn("row4col2", 8'h02, 8'h12, 8'h22, 8'h32, 8'h42);
            end
        end

        $display("[TB] same stream restarted by sof, valid toggling");
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus(1'b1, (r == 0 && c == 0), 8'(16 * r + c));
                if (r == 4 && c == 2) checkColumn("gap_row4col2", 8'h02, 8'h12, 8'h22, 8'h32, 8'h42);
                applyStimulus(1'b0, 1'b0, 8'h00);
            end
        end

        $display("[TB] sof mid-line");
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b0, 8'(8'h50 + c));
        applyStimulus(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 4 * W - 1; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        applyStimulus(1'b1, 1'b0, 8'($urandom));
        checkOutput("newframe_row4col0_pixel0", int'(bus.pixel0), 8'hAA);

        $display("[TB] reset mid row 6");
        for (int i = 0; i < 2 * W + 2; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
        doReset();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < W; c++) begin
                applyStimulus(1'b1, 1'b0, 8'(16 * r + c));
`ifdef FIR_LB_TOP_PAD_EN
                if (r == 1 && c == 5) begin
                    checkOutput("pad_out_valid", int'(bus.out_valid), 1);
                    checkColumn("pad_row1col5", 8'h00, 8'h00, 8'h00, 8'h05, 8'h15);
                end
`endif
            end
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                logic v;
                v = ($urandom_range(0, 9) < 7);
                applyStimulus(v, v && ($urandom_range(0, 79) == 0), 8'($urandom));
            end
        end

        applyStimulus(1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
